// File: rtl/gate_bist_ctrl.sv
// rtl/gate_bist_ctrl.sv - BIST sequencer: walks all gate input vectors, counts mismatches
module gate_bist_ctrl #(
    parameter int                        N_IN   = 2,
    parameter logic [(1 << N_IN) - 1:0]  TRUTH  = 4'b1000,
    parameter int                        SETTLE = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_dut_q,
    output logic [N_IN-1:0]   o_vec,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_aborted,
    output logic [N_IN:0]     o_err_count,
    output logic              o_fail_valid,
    output logic [N_IN-1:0]   o_fail_vec
);

    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};
    localparam logic [7:0]      CNT_LAST = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_cnt;
    logic [N_IN-1:0] r_vec;
    logic [N_IN:0]   r_err;
    logic            r_fail_valid;
    logic [N_IN-1:0] r_fail_vec;
    logic            r_pass;
    logic            r_aborted;
    logic            w_mismatch;

    assign w_mismatch = (i_dut_q != TRUTH[r_vec]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (i_abort) begin
                    w_next = S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (i_abort || (r_vec == LAST_VEC)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_SETTLE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Abort takes precedence over counting and compare so the abort cycle never scores.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_vec        <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
            r_pass       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cnt        <= '0;
                        r_vec        <= '0;
                        r_err        <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= '0;
                        r_pass       <= 1'b0;
                        r_aborted    <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (i_abort) begin
                        r_aborted <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_CHECK: begin
                    if (i_abort) begin
                        r_aborted <= 1'b1;
                    end else begin
                        if (w_mismatch) begin
                            r_err <= r_err + (N_IN+1)'(1);
                            if (!r_fail_valid) begin
                                r_fail_valid <= 1'b1;
                                r_fail_vec   <= r_vec;
                            end
                        end
                        if (r_vec != LAST_VEC) begin
                            r_vec <= r_vec + N_IN'(1);
                            r_cnt <= '0;
                        end
                    end
                end
                S_DONE: begin
                    r_pass <= !r_aborted && (r_err == '0);
                end
                default: begin
                end
            endcase
        end
    end

    assign o_vec        = r_vec;
    assign o_busy       = (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign o_done       = (r_state == S_DONE);
    assign o_pass       = r_pass;
    assign o_aborted    = r_aborted;
    assign o_err_count  = r_err;
    assign o_fail_valid = r_fail_valid;
    assign o_fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb/tb_gate_bist_ctrl.sv - bench for gate_bist_ctrl against a truth-table reference model
module tb_gate_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, start_b;
    logic [3:0] gate_tbl;
    logic [1:0] vec_a, fvec_a, vec_b, fvec_b;
    logic       busy_a, done_a, pass_a, ab_a, fv_a, q_a;
    logic       busy_b, done_b, pass_b, ab_b, fv_b, q_b;
    logic [2:0] err_a, err_b;

    int errors = 0;
    int checks = 0;

    assign q_a = gate_tbl[vec_a];
    assign q_b = vec_b[0] & vec_b[1];

    gate_bist_ctrl #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(2)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort), .i_dut_q(q_a),
        .o_vec(vec_a), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
        .o_aborted(ab_a), .o_err_count(err_a), .o_fail_valid(fv_a), .o_fail_vec(fvec_a)
    );

    gate_bist_ctrl #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_abort(1'b0), .i_dut_q(q_b),
        .o_vec(vec_b), .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
        .o_aborted(ab_b), .o_err_count(err_b), .o_fail_valid(fv_b), .o_fail_vec(fvec_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a 2-input AND is 1 only when both input bits are 1.
    function automatic logic and_ref(input int v);
        return ((v % 2) == 1) && ((v / 2) == 1);
    endfunction

    function automatic int ref_errs(input logic [3:0] t);
        int n = 0;
        for (int v = 0; v < 4; v++) if (t[v] != and_ref(v)) n++;
        return n;
    endfunction

    function automatic int ref_first(input logic [3:0] t);
        for (int v = 0; v < 4; v++) if (t[v] != and_ref(v)) return v;
        return 0;
    endfunction

    // Full run on instance A; optional abort with start, optional start re-pulses at cycles 4 and 13.
    task automatic run_a(input logic [3:0] t, input logic with_abort, input logic repulse);
        int ne;
        ne = ref_errs(t);
        gate_tbl = t;
        start = 1'b1;
        abort = with_abort;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            chk("vec_seq", vec_a, (k - 1) / 3);
            chk("busy_run", busy_a, 1);
            chk("done_early", done_a, 0);
            if (repulse && k == 4) start = 1'b1;
            step();
            start = 1'b0;
        end
        chk("done_c13", done_a, 1);
        chk("busy_done", busy_a, 0);
        chk("vec_hold", vec_a, 3);
        if (repulse) start = 1'b1;
        step();
        start = 1'b0;
        chk("done_pulse_end", done_a, 0);
        chk("busy_after", busy_a, 0);
        chk("err_count", err_a, ne);
        chk("fail_valid", fv_a, ne != 0);
        if (ne != 0) chk("fail_vec", fvec_a, ref_first(t));
        chk("pass", pass_a, ne == 0);
        chk("aborted_clr", ab_a, 0);
    endtask

    task automatic abort_run(input logic [3:0] t, input int acyc);
        int ne;
        ne = 0;
        for (int v = 0; v < 4; v++)
            if (((v + 1) * 3) < acyc && t[v] != and_ref(v)) ne++;
        gate_tbl = t;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < acyc; k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_done", done_a, 1);
        chk("abort_busy", busy_a, 0);
        chk("abort_flag", ab_a, 1);
        chk("abort_err", err_a, ne);
        step();
        chk("abort_pass", pass_a, 0);
        chk("abort_done_end", done_a, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vec"}, vec_a, 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_pass"}, pass_a, 0);
        chk({tag, "_abrt"}, ab_a, 0);
        chk({tag, "_err"}, err_a, 0);
        chk({tag, "_fv"}, fv_a, 0);
        chk({tag, "_fvec"}, fvec_a, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; start_b = 1'b0; gate_tbl = 4'b1000;
        step();
        step();
        rst = 1'b0;
        chk_reset_vals("reset");

        run_a(4'b1000, 1'b0, 1'b0);
        run_a(4'b0000, 1'b0, 1'b0);
        run_a(4'b1111, 1'b0, 1'b0);
        run_a(4'b1111, 1'b0, 1'b1);
        run_a(4'b1000, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) run_a(4'($urandom), r[0], 1'b0);

        abort_run(4'b1111, 5);
        abort_run(4'b1111, 6);
        run_a(4'b1000, 1'b0, 1'b0);

        gate_tbl = 4'b0000;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 7; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("midrst");
        step();
        chk("midrst_nodone", done_a, 0);

        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("b_vec_seq", vec_b, (k - 1) / 2);
            chk("b_done_early", done_b, 0);
            step();
        end
        chk("b_done_c9", done_b, 1);
        step();
        chk("b_pass", pass_b, 1);
        chk("b_err", err_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
